// File: rtl/packetizer_2_sub_pkg.sv
// Shared definitions for the two-slot packetizer: header bit offsets and
// the flit-count helper used to size and validate a configuration.
package packetizer_2_sub_pkg;

  // Header bit offsets, counted down from the flit MSB.
  localparam int HDR_VALID = 0;
  localparam int HDR_HEAD  = 1;
  localparam int HDR_TAIL  = 2;
  localparam int HDR_BITS  = 3;

  // Number of flits needed for a payload of width_in bits, given the head
  // and body payload capacities. Returns 0 when the payload cannot fit.
  function automatic int flit_count(input int width_in, input int hp, input int bp);
    int n;
    if (width_in <= hp) begin
      n = 1;
    end else if (width_in <= hp + bp) begin
      n = 2;
    end else begin
      n = 0;
    end
    return n;
  endfunction

endpackage

// File: rtl/flit_formatter.sv
// Packs one flit: valid/head/tail header, vc, optional dst (head flits
// only) and payload. Purely combinational; all-zero inputs give a zero flit.
module flit_formatter
  import packetizer_2_sub_pkg::*;
#(
  parameter int FW  = 18,
  parameter int VCW = 1,
  parameter int AW  = 4
) (
  input  logic                      head_i,
  input  logic                      tail_i,
  input  logic                      valid_i,
  input  logic [VCW-1:0]            vc_i,
  input  logic [AW-1:0]             dst_i,
  input  logic [FW-HDR_BITS-VCW-1:0] payload_i,
  output logic [FW-1:0]             flit_o
);

  localparam int BPW = FW - HDR_BITS - VCW;
  localparam int HPW = BPW - AW;

  // Place header, vc and payload; head flits carry dst below vc and a
  // correspondingly narrower payload.
  always_comb begin
    flit_o = {FW{1'b0}};
    flit_o[FW-1-HDR_VALID] = valid_i;
    flit_o[FW-1-HDR_HEAD]  = head_i;
    flit_o[FW-1-HDR_TAIL]  = tail_i;
    flit_o[FW-1-HDR_BITS -: VCW] = vc_i;
    if (head_i) begin
      flit_o[FW-1-HDR_BITS-VCW -: AW] = dst_i;
      flit_o[HPW-1:0] = payload_i[HPW-1:0];
    end else begin
      flit_o[BPW-1:0] = payload_i;
    end
  end

endmodule

// File: rtl/packetizer_2_sub.sv
// Packetizer: splits a payload into one or two flits (head/body), packs
// them into a two-slot output word and holds it in a single ready/valid
// output register with one-cycle latency and full throughput.
module packetizer_2_sub
  import packetizer_2_sub_pkg::*;
#(
  parameter int ADDRESS_WIDTH    = 4,
  parameter int VC_ADDRESS_WIDTH = 1,
  parameter int WIDTH_IN         = 12,
  parameter int WIDTH_OUT        = 36
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [WIDTH_IN-1:0]         data_in,
  input  logic                        valid_in,
  input  logic [ADDRESS_WIDTH-1:0]    dst_in,
  input  logic [VC_ADDRESS_WIDTH-1:0] vc_in,
  output logic                        ready_out,
  output logic [WIDTH_OUT-1:0]        data_out,
  output logic                        valid_out,
  input  logic                        ready_in
);

  localparam int FW     = WIDTH_OUT / 2;
  localparam int BP     = FW - HDR_BITS - VC_ADDRESS_WIDTH;
  localparam int HP     = BP - ADDRESS_WIDTH;
  localparam int NFLITS = flit_count(WIDTH_IN, HP, BP);

  // Positions of the two per-flit valid bits, cleared when the word drains.
  localparam logic [WIDTH_OUT-1:0] VALID_MASK =
      ({{(WIDTH_OUT-1){1'b0}}, 1'b1} << (WIDTH_OUT-1-HDR_VALID)) |
      ({{(WIDTH_OUT-1){1'b0}}, 1'b1} << (FW-1-HDR_VALID));

  if ((WIDTH_OUT % 2) != 0) begin : g_bad_width_out
    $error("packetizer_2_sub: WIDTH_OUT (%0d) must be even", WIDTH_OUT);
  end
  if (NFLITS == 0) begin : g_bad_width_in
    $error("packetizer_2_sub: WIDTH_IN (%0d) exceeds head+body capacity (%0d)", WIDTH_IN, HP + BP);
  end

  logic [HP+BP-1:0]            data_ext_s;
  logic [BP-1:0]               head_pl_s;
  logic [BP-1:0]               body_pl_s;
  logic                        f1_head_s;
  logic                        f1_tail_s;
  logic                        f1_valid_s;
  logic [VC_ADDRESS_WIDTH-1:0] f1_vc_s;
  logic                        f0_tail_s;
  logic [FW-1:0]               flit0_s;
  logic [FW-1:0]               flit1_s;
  logic                        accept_s;
  logic                        valid_q;
  logic                        valid_d;
  logic [WIDTH_OUT-1:0]        data_q;
  logic [WIDTH_OUT-1:0]        data_d;

  // Split the payload: low HP bits to the head flit, the rest zero-extended
  // into the body flit; the body slot is left all-zero for single-flit packets.
  always_comb begin
    data_ext_s = {(HP+BP){1'b0}};
    data_ext_s[WIDTH_IN-1:0] = data_in;
    head_pl_s = {{ADDRESS_WIDTH{1'b0}}, data_ext_s[HP-1:0]};
    if (NFLITS == 2) begin
      f0_tail_s  = 1'b0;
      f1_head_s  = 1'b0;
      f1_tail_s  = 1'b1;
      f1_valid_s = 1'b1;
      f1_vc_s    = vc_in;
      body_pl_s  = data_ext_s[HP+BP-1:HP];
    end else begin
      f0_tail_s  = 1'b1;
      f1_head_s  = 1'b0;
      f1_tail_s  = 1'b0;
      f1_valid_s = 1'b0;
      f1_vc_s    = {VC_ADDRESS_WIDTH{1'b0}};
      body_pl_s  = {BP{1'b0}};
    end
  end

  flit_formatter #(
    .FW  (FW),
    .VCW (VC_ADDRESS_WIDTH),
    .AW  (ADDRESS_WIDTH)
  ) u_fmt_head (
    .head_i    (1'b1),
    .tail_i    (f0_tail_s),
    .valid_i   (1'b1),
    .vc_i      (vc_in),
    .dst_i     (dst_in),
    .payload_i (head_pl_s),
    .flit_o    (flit0_s)
  );

  flit_formatter #(
    .FW  (FW),
    .VCW (VC_ADDRESS_WIDTH),
    .AW  (ADDRESS_WIDTH)
  ) u_fmt_body (
    .head_i    (f1_head_s),
    .tail_i    (f1_tail_s),
    .valid_i   (f1_valid_s),
    .vc_i      (f1_vc_s),
    .dst_i     ({ADDRESS_WIDTH{1'b0}}),
    .payload_i (body_pl_s),
    .flit_o    (flit1_s)
  );

  assign ready_out = !valid_q || ready_in;
  assign accept_s  = valid_in && ready_out;

  // Next-state: load on accept (also covers accept+drain), clear the valid
  // bits on drain while keeping the payload, otherwise hold.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (accept_s) begin
      valid_d = 1'b1;
      data_d  = {flit0_s, flit1_s};
    end else if (ready_in) begin
      valid_d = 1'b0;
      data_d  = data_q & ~VALID_MASK;
    end else begin
      valid_d = valid_q;
      data_d  = data_q;
    end
  end

  // Output register; reset discards any held packet.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH_OUT{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_packetizer_2_sub.sv
// Directed/table-driven bench for packetizer_2_sub plus a random
// ready/valid scoreboard run and a single-flit configuration instance.
module tb_packetizer_2_sub;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] data_in;
  logic        valid_in;
  logic [3:0]  dst_in;
  logic        vc_in;
  logic        ready_out;
  logic [35:0] data_out;
  logic        valid_out;
  logic        ready_in;

  logic [7:0]  data8_in;
  logic        valid8_in;
  logic [3:0]  dst8_in;
  logic        vc8_in;
  logic        ready8_out;
  logic [35:0] data8_out;
  logic        valid8_out;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  packetizer_2_sub u_dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .dst_in    (dst_in),
    .vc_in     (vc_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .valid_out (valid_out),
    .ready_in  (ready_in)
  );

  packetizer_2_sub #(.WIDTH_IN(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data8_in),
    .valid_in  (valid8_in),
    .dst_in    (dst8_in),
    .vc_in     (vc8_in),
    .ready_out (ready8_out),
    .data_out  (data8_out),
    .valid_out (valid8_out),
    .ready_in  (ready_in)
  );

  typedef struct {
    logic [11:0] data;
    logic [3:0]  dst;
    logic        vc;
    logic [35:0] exp;
  } vec_t;

  vec_t vecs [6];
  logic [35:0] sbq [$];
  logic        exp_ready;
  logic [35:0] exp_word;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference layout for the default configuration (FW=18, HP=10, BP=14).
  function automatic logic [35:0] fmt12(input logic [11:0] d, input logic [3:0] dst, input logic vc);
    logic [17:0] f0;
    logic [17:0] f1;
    f0 = {1'b1, 1'b1, 1'b0, vc, dst, d[9:0]};
    f1 = {1'b1, 1'b0, 1'b1, vc, 12'h000, d[11:10]};
    return {f0, f1};
  endfunction

  initial begin
    vecs[0] = '{12'hABC, 4'h5, 1'b1, 36'hD5AF2C002};
    vecs[1] = '{12'h000, 4'h0, 1'b0, 36'hC00028000};
    vecs[2] = '{12'hFFF, 4'hF, 1'b1, 36'hDFFFEC003};
    vecs[3] = '{12'h400, 4'hA, 1'b0, 36'hCA0028001};
    vecs[4] = '{12'h3FF, 4'h0, 1'b1, 36'hD0FFEC000};
    vecs[5] = '{12'h801, 4'h1, 1'b0, 36'hC10068002};

    rst = 1'b1;
    data_in = 12'h000; valid_in = 1'b0; dst_in = 4'h0; vc_in = 1'b0; ready_in = 1'b0;
    data8_in = 8'h00; valid8_in = 1'b0; dst8_in = 4'h0; vc8_in = 1'b0;

    // Reset state
    #12;
    check("rst_valid", valid_out, 1'b0);
    check("rst_data", data_out, 36'h0);
    check("rst_ready", ready_out, 1'b1);
    check("rst_ready8", ready8_out, 1'b1);
    tick();
    rst = 1'b0;

    // Back-to-back stream of table vectors; each checked one cycle later.
    for (int i = 0; i < 6; i++) begin
      data_in = vecs[i].data; dst_in = vecs[i].dst; vc_in = vecs[i].vc;
      valid_in = 1'b1; ready_in = 1'b1;
      tick();
      check($sformatf("vec%0d_valid", i), valid_out, 1'b1);
      check($sformatf("vec%0d_data", i), data_out, vecs[i].exp);
    end

    // Drain with no new accept: valid bits drop, payload retained.
    valid_in = 1'b0; data_in = 12'h555; dst_in = 4'h7;
    tick();
    check("drain_valid", valid_out, 1'b0);
    check("drain_data", data_out, 36'h410048002);
    tick();
    check("idle_noload_data", data_out, 36'h410048002);
    check("idle_noload_valid", valid_out, 1'b0);

    // Backpressure: load, then stall three cycles with a competing input.
    data_in = 12'hABC; dst_in = 4'h5; vc_in = 1'b1; valid_in = 1'b1; ready_in = 1'b1;
    tick();
    check("bp_load", data_out, 36'hD5AF2C002);
    data_in = 12'h123; dst_in = 4'h2; vc_in = 1'b0; ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d_ready", k), ready_out, 1'b0);
      tick();
      check($sformatf("bp%0d_data", k), data_out, 36'hD5AF2C002);
      check($sformatf("bp%0d_valid", k), valid_out, 1'b1);
    end
    // Release: ready_out follows immediately; accept+drain in same cycle.
    data_in = 12'h000; dst_in = 4'h0; vc_in = 1'b0; ready_in = 1'b1;
    #1;
    check("bp_release_ready", ready_out, 1'b1);
    tick();
    check("swap_valid", valid_out, 1'b1);
    check("swap_data", data_out, 36'hC00028000);

    // Asynchronous reset mid-cycle while holding a packet.
    valid_in = 1'b0; ready_in = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", valid_out, 1'b0);
    check("arst_data", data_out, 36'h0);
    check("arst_ready", ready_out, 1'b1);
    tick();
    rst = 1'b0;
    data_in = 12'h3FF; dst_in = 4'h0; vc_in = 1'b1; valid_in = 1'b1;
    tick();
    check("post_rst_valid", valid_out, 1'b1);
    check("post_rst_data", data_out, 36'hD0FFEC000);

    // Single-flit configuration.
    valid_in = 1'b0; ready_in = 1'b1;
    data8_in = 8'hFF; dst8_in = 4'h3; vc8_in = 1'b0; valid8_in = 1'b1;
    tick();
    check("w8_valid", valid8_out, 1'b1);
    check("w8_flit0", data8_out[35:18], 18'h38CFF);
    check("w8_flit1", data8_out[17:0], 18'h00000);
    valid8_in = 1'b0;
    tick();
    check("w8_drain_valid", valid8_out, 1'b0);

    // Random valid/ready with a FIFO scoreboard.
    for (int c = 0; c < 10000; c++) begin
      valid_in = 1'($urandom_range(0, 1));
      ready_in = 1'($urandom_range(0, 1));
      data_in  = 12'($urandom);
      dst_in   = 4'($urandom);
      vc_in    = 1'($urandom);
      #1;
      exp_ready = (sbq.size() == 0) || ready_in;
      check("rnd_ready", ready_out, exp_ready);
      check("rnd_valid", valid_out, (sbq.size() != 0));
      if ((sbq.size() != 0) && ready_in) begin
        exp_word = sbq.pop_front();
        check("rnd_data", data_out, exp_word);
      end
      if (valid_in && exp_ready) begin
        sbq.push_back(fmt12(data_in, dst_in, vc_in));
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
